// File: rtl/scf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : scf_arbiter
// Purpose  : Round-robin arbiter that shares one SCF control-flow filter among
//            NREQ commit-trace requesters. The granted record is captured in a
//            one-entry stage register, filtered and pushed into an output FIFO
//            with a valid/ready handshake toward the CFI checker.
// Ports    : clk, rst_n (async, active low)
//            req_valid[NREQ], req_data[64*NREQ] -> req_ready[NREQ] (one-hot/0)
//            out_valid, out_data[64] <- out_ready (FIFO head, non-fall-through)
//            grant_id   : index of the last accepted requester
//            fwd_count  : records written to the FIFO (saturating)
//            zero_count : filtered results equal to 0 (saturating)
//            busy       : stage register or FIFO non-empty
// Options  : SCF_DROP_ZERO_EN - discard zero results instead of queueing them
// Revision : 1.0 - initial release
// ============================================================================
module scf_arbiter #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [64*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    output logic [63:0]              out_data,
    input  logic                     out_ready,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic [CW-1:0]            fwd_count,
    output logic [CW-1:0]            zero_count,
    output logic                     busy
);

    localparam int                c_IW      = $clog2(NREQ);
    localparam int                c_PW      = $clog2(DEPTH);
    localparam int                c_NW      = c_PW + 1;
    localparam logic [c_IW-1:0]   c_PTR_RST = c_IW'(NREQ - 1);
    localparam logic [c_NW-1:0]   c_DEPTH_N = c_NW'(DEPTH);
    localparam logic [CW-1:0]     c_SAT     = '1;

    // Returns 0 for control-flow records whose qualifier/target is null.
    function automatic logic [63:0] f_scf_filter(input logic [63:0] rec);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [25:0] tgt;
        logic        q0;
        logic        kill;
        op   = rec[31:26];
        fn   = rec[5:0];
        rt   = rec[20:16];
        tgt  = rec[25:0];
        q0   = (rec[63:32] == 32'd0);
        kill = 1'b0;
        case (op)
            6'd0:                   kill = q0 && (fn == 6'd8 || fn == 6'd9);
            6'd1:                   kill = q0 && (rt == 5'd0 || rt == 5'd1 ||
                                                  rt == 5'd16 || rt == 5'd17);
            6'd2, 6'd3:             kill = (tgt == 26'd0);
            6'd4, 6'd5, 6'd6, 6'd7: kill = q0;
            default:                kill = 1'b0;
        endcase
        return kill ? 64'd0 : rec;
    endfunction

    logic [c_IW-1:0] r_ptr;
    logic [c_IW-1:0] r_grant;
    logic            r_stage_valid;
    logic [63:0]     r_stage_data;
    logic [63:0]     r_mem [DEPTH];
    logic [c_PW-1:0] r_wr;
    logic [c_PW-1:0] r_rd;
    logic [c_NW-1:0] r_cnt;
    logic [CW-1:0]   r_fwd;
    logic [CW-1:0]   r_zero;

    logic [c_IW-1:0] w_cand;
    logic            w_found;
    logic [63:0]     w_cand_data;
    logic            w_accept_ok;
    logic            w_accept;
    logic            w_pop;
    logic            w_full;
    logic [63:0]     w_result;
    logic            w_res_zero;
    logic            w_drain;
    logic            w_push;

    // Rotating priority search starting just after the last grant.
    always_comb begin
        logic [c_IW-1:0] w_idx;
        w_found = 1'b0;
        w_cand  = r_ptr;
        w_idx   = r_ptr;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = c_IW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_cand  = w_idx;
            end
        end
    end

    assign w_cand_data = req_data[{w_cand, 6'b0} +: 64];
    assign w_full      = (r_cnt == c_DEPTH_N);
    assign out_valid   = (r_cnt != '0);
    assign w_pop       = out_ready & out_valid;
    assign w_result    = f_scf_filter(r_stage_data);
    assign w_res_zero  = (w_result == 64'd0);

`ifdef SCF_DROP_ZERO_EN
    // A zero result never needs FIFO room, so it drains even when full.
    assign w_drain = r_stage_valid & (~w_full | w_pop | w_res_zero);
    assign w_push  = w_drain & ~w_res_zero;
`else
    assign w_drain = r_stage_valid & (~w_full | w_pop);
    assign w_push  = w_drain;
`endif

    assign w_accept_ok = ~r_stage_valid | w_drain;
    assign w_accept    = rst_n & w_found & w_accept_ok;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_cand] = 1'b1;
        end
    end

    // Head is gated so out_data reads 0 whenever the FIFO is empty.
    assign out_data   = out_valid ? r_mem[r_rd] : 64'd0;
    assign grant_id   = r_grant;
    assign fwd_count  = r_fwd;
    assign zero_count = r_zero;
    assign busy       = r_stage_valid | out_valid;

    // Arbiter pointer and stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= c_PTR_RST;
            r_grant       <= '0;
            r_stage_valid <= 1'b0;
            r_stage_data  <= 64'd0;
        end else begin
            if (w_accept) begin
                r_ptr         <= w_cand;
                r_grant       <= w_cand;
                r_stage_valid <= 1'b1;
                r_stage_data  <= w_cand_data;
            end else if (w_drain) begin
                r_stage_valid <= 1'b0;
            end
        end
    end

    // FIFO storage carries no reset; the gated head hides stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_fwd  <= '0;
            r_zero <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_push && r_fwd != c_SAT) begin
                r_fwd <= r_fwd + 1'b1;
            end
            if (w_drain && w_res_zero && r_zero != c_SAT) begin
                r_zero <= r_zero + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_scf_arbiter
// Purpose  : Self-checking bench for scf_arbiter. A queue-based reference model
//            predicts every output each cycle; directed sequences add literal
//            expectations for reset, latency, filtering, backpressure and
//            mid-run reset. Honours SCF_DROP_ZERO_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scf_arbiter;

    localparam int NREQ  = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int c_MAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [64*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [63:0]          out_data;
    logic                 out_ready;
    logic [0:0]           grant_id;
    logic [CW-1:0]        fwd_count;
    logic [CW-1:0]        zero_count;
    logic                 busy;

    scf_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .grant_id   (grant_id),
        .fwd_count  (fwd_count),
        .zero_count (zero_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: FIFO as a queue, optional stage record.
    logic [63:0] m_q[$];
    bit          m_sv;
    logic [63:0] m_sd;
    int          m_ptr;
    int          m_gid;
    int          m_fwd;
    int          m_zero;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_filter(input logic [63:0] rec);
        int unsigned op  = rec[31:26];
        int unsigned fn  = rec[5:0];
        int unsigned rt  = rec[20:16];
        int unsigned tgt = rec[25:0];
        bit qz = (rec[63:32] == 0);
        bit kill;
        kill = ((op inside {[4:7]}) && qz)
            || ((op inside {2, 3}) && tgt == 0)
            || (op == 0 && (fn inside {8, 9}) && qz)
            || (op == 1 && (rt inside {0, 1, 16, 17}) && qz);
        return kill ? 64'd0 : rec;
    endfunction

    function automatic int ref_cand();
        for (int k = 1; k <= NREQ; k++) begin
            int j = (m_ptr + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit ref_drain();
        bit pop = out_ready && m_q.size() > 0;
        bit room = (m_q.size() < DEPTH) || pop;
`ifdef SCF_DROP_ZERO_EN
        room = room || (ref_filter(m_sd) == 64'd0);
`endif
        return m_sv && room;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sv   = 1'b0;
        m_sd   = 64'd0;
        m_ptr  = NREQ - 1;
        m_gid  = 0;
        m_fwd  = 0;
        m_zero = 0;
    endtask

    task automatic compare();
        logic [NREQ-1:0] exp_rdy = '0;
        int c = ref_cand();
        if (rst_n && c >= 0 && (!m_sv || ref_drain())) exp_rdy[c] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("out_valid", out_valid, m_q.size() > 0);
        chk("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 64'd0);
        chk("grant_id", grant_id, m_gid);
        chk("fwd_count", fwd_count, m_fwd);
        chk("zero_count", zero_count, m_zero);
        chk("busy", busy, m_sv || m_q.size() > 0);
    endtask

    task automatic model_step();
        bit pop, drain, acc;
        int c;
        logic [63:0] r;
        if (!rst_n) return;
        pop   = out_ready && m_q.size() > 0;
        drain = ref_drain();
        c     = ref_cand();
        acc   = (c >= 0) && (!m_sv || drain);
        if (pop) void'(m_q.pop_front());
        if (drain) begin
            r = ref_filter(m_sd);
            if (r == 64'd0 && m_zero < c_MAX) m_zero++;
`ifdef SCF_DROP_ZERO_EN
            if (r != 64'd0) begin
                m_q.push_back(r);
                if (m_fwd < c_MAX) m_fwd++;
            end
`else
            m_q.push_back(r);
            if (m_fwd < c_MAX) m_fwd++;
`endif
        end
        if (acc) begin
            m_sd  = req_data[c*64 +: 64];
            m_sv  = 1'b1;
            m_ptr = c;
            m_gid = c;
        end else if (drain) begin
            m_sv = 1'b0;
        end
    endtask

    // Inputs are set at the falling edge; this checks, advances the model and
    // returns at the next falling edge.
    task automatic step();
        #1;
        compare();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] gen_rec();
        logic [31:0] w = $urandom;
        logic [31:0] q = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom);
        logic [4:0]  rts [4] = '{5'd0, 5'd1, 5'd16, 5'd17};
        case ($urandom_range(0, 5))
            0: w[31:26] = 6'($urandom_range(4, 7));
            1: begin
                w[31:26] = 6'($urandom_range(2, 3));
                if ($urandom_range(0, 1) == 0) w[25:0] = 26'd0;
            end
            2: begin
                w[31:26] = 6'd0;
                if ($urandom_range(0, 1) == 0) w[5:0] = 6'($urandom_range(8, 9));
            end
            3: begin
                w[31:26] = 6'd1;
                if ($urandom_range(0, 1) == 0) w[20:16] = rts[$urandom_range(0, 3)];
            end
            default: ;
        endcase
        return {q, w};
    endfunction

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fwd", fwd_count, 0);
        chk("rst_zero", zero_count, 0);
        chk("rst_gid", grant_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        // beq with q=4 passes; visible two edges after being offered.
        out_ready = 1'b1;
        req_valid = 2'b01;
        req_data[63:0] = 64'h00000004_10220003;
        step();
        req_valid = '0;
        step();
        #1;
        chk("beq_valid", out_valid, 1);
        chk("beq_data", out_data, 64'h00000004_10220003);
        chk("beq_fwd", fwd_count, 1);
        step();

        // j with tgt=0 filters to zero.
        req_valid = 2'b01;
        req_data[63:0] = 64'h00000000_08000000;
        step();
        req_valid = '0;
        step();
        #1;
        chk("j_zero", zero_count, 1);
`ifdef SCF_DROP_ZERO_EN
        chk("j_valid", out_valid, 0);
        chk("j_fwd", fwd_count, 1);
`else
        chk("j_valid", out_valid, 1);
        chk("j_data", out_data, 0);
        chk("j_fwd", fwd_count, 2);
`endif
        step();

        // add with q=0 passes unchanged, jr with q=0 becomes zero.
        req_valid = 2'b01;
        req_data[63:0] = 64'h00000000_00851020;
        step();
        req_data[63:0] = 64'h00000000_03E00008;
        step();
        req_valid = '0;
        #1;
        chk("add_data", out_data, 64'h00000000_00851020);
        step();
        #1;
        chk("jr_zero", zero_count, 2);
`ifdef SCF_DROP_ZERO_EN
        chk("jr_valid", out_valid, 0);
`else
        chk("jr_data", out_data, 0);
        chk("jr_valid", out_valid, 1);
`endif
        step();
        step();

        // Both requesters busy: grants alternate, starting with req1.
        req_valid = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            req_data = {gen_rec(), gen_rec()};
            step();
            #1;
            chk("alt_gid", grant_id, (k % 2) ? 1 : 0);
        end
        req_valid = '0;
        repeat (3) step();

        // Backpressure: FIFO fills, stage holds the fifth record.
        out_ready = 1'b0;
        req_valid = 2'b01;
        for (int k = 0; k < 7; k++) begin
            req_data[63:0] = {32'($urandom), 32'h00851020};
            step();
        end
        #1;
        chk("full_ready", req_ready, 0);
        chk("full_busy", busy, 1);
        out_ready = 1'b1;
        #1;
        chk("pop_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        repeat (6) step();

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            req_valid = NREQ'($urandom);
            req_data  = {gen_rec(), gen_rec()};
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Mid-run reset with three entries buffered.
        req_valid = '0;
        out_ready = 1'b1;
        repeat (6) step();
        out_ready = 1'b0;
        req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            req_data[63:0] = {32'h00000004, 32'h00851020};
            step();
        end
        req_valid = '0;
        step();
        #1;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fwd", fwd_count, 0);
        chk("mid_rst_zero", zero_count, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_data = {gen_rec(), gen_rec()};
        #1;
        chk("post_rst_ready", req_ready, 2'b01);
        step();
        #1;
        chk("post_rst_gid", grant_id, 0);
        req_valid = '0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scf_arbiter.md
Name: scf_arbiter

Overview:
- Shares one control-flow filter datapath among NREQ commit-trace requesters.
- Each requester presents a 64-bit record: [31:0] is the instruction word, [63:32] is the qualifier (PC or target tag).
- The block arbitrates round-robin, registers the granted record, applies the SCF filter rule, and buffers results in an output FIFO with a valid/ready handshake.
- It sits between the core trace ports and the CFI checker.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DEPTH, 4, output FIFO entries (power of two, ≥2).
- CW, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester record valid.
- req_data  in  64*NREQ  records; requester k occupies bits [64k+63:64k].
- req_ready  out  NREQ  one-hot-or-zero accept strobe.
- out_valid  out  1  FIFO head valid.
- out_data  out  64  FIFO head record.
- out_ready  in  1  downstream pop.
- grant_id  out  $clog2(NREQ)  index of the last accepted requester.
- fwd_count  out  CW  records written to the FIFO; saturating.
- zero_count  out  CW  filtered results equal to 0; saturating.
- busy  out  1  stage register or FIFO non-empty.

Behaviour:
- Reset values while rst_n=0: all outputs 0; FIFO empty; stage empty; rr pointer=NREQ-1, so requester 0 has first priority.
- Field extraction: op=rec[31:26], fn=rec[5:0], rt=rec[20:16], tgt=rec[25:0], q=rec[63:32].
- Filter rule, result = rec unless one of these zeroes it (result = 0):
  - op∈{4,5,6,7} and q==0;
  - op∈{2,3} and tgt==0;
  - op==0, fn∈{8,9} and q==0;
  - op==1, rt∈{0,1,16,17} and q==0.
  - All other records pass unchanged.
- Arbiter:
  - Search starts at pointer+1 (mod NREQ); the first requester with req_valid=1 is the candidate.
  - req_ready[cand]=1 only when accept_ok; every other req_ready bit is 0.
  - accept_ok = !stage_valid | stage_drain.
  - The pointer and grant_id update only on an accepted transfer (req_valid & req_ready).
- Stage:
  - On accept, the stage captures the granted record; stage_valid=1.
  - stage_drain = stage_valid & (fifo_cnt<DEPTH | out_ready&out_valid).
  - On drain, the filtered result is written to the FIFO.
- Latency: a record accepted at edge N is written to the FIFO at edge N+1 and shows out_valid=1 after edge N+1, provided the FIFO has room. Throughput is 1 record/clk.
- FIFO:
  - Non-fall-through; out_data is the head.
  - Simultaneous push and pop while full is legal; the count stays at DEPTH.
  - A pop while empty is ignored.
  - Pointers wrap modulo DEPTH.
- Counters:
  - fwd_count increments on each FIFO write.
  - zero_count increments on each drained result equal to 0.
  - Both saturate at all-ones.
- req_valid may drop without a grant; the arbiter holds no lock.
- rst_n asserted mid-operation: the stage and FIFO contents are discarded immediately, with no handshake on exit.

Optional Feature:
- Macro: SCF_DROP_ZERO_EN.
- Defined:
  - Drained results equal to 0 are discarded and not written to the FIFO.
  - fwd_count is not incremented for them; zero_count is.
  - A discard still drains the stage, even when the FIFO is full.
- Undefined: zero results are written to the FIFO like any other result.

Test Plan:
- Reset, idle → all outputs 0, req_ready=0; first request from req0 with data 64'h00000004_10220003 (beq, q=4) → out_data equals the record 2 edges later, fwd_count=1.
- Both requesters valid continuously, out_ready=1 → grants alternate 0,1,0,1; one record/clk; grant_id toggles.
- req0 data 64'h00000000_08000000 (j, tgt=0) → out_data=0, zero_count=1; with SCF_DROP_ZERO_EN → no out_valid, fwd_count=0, zero_count=1.
- out_ready=0, DEPTH+1 records offered → FIFO fills to 4 and the stage holds the fifth; req_ready=0 thereafter; one pop → the stage drains in the same cycle and req_ready returns.
- Non-CF record 64'h00000000_00851020 (add) with q=0 → forwarded unchanged; jr 64'h00000000_03E00008 → 0.
- rst_n pulsed low with 3 entries buffered → out_valid=0 immediately, busy=0, counters 0, pointer reset (req0 wins next).
